// File: rtl/mux_lut_loader_if.sv
// Write port of the LUT loader: one {key, value} entry per valid/ready transfer.
// The requester holds valid/key/val stable until the loader raises ready.
interface mux_lut_loader_if #(
  parameter int KEY_WIDTH = 1,
  parameter int VAL_WIDTH = 1
);
  logic                 i_wr_valid;
  logic                 o_wr_ready;
  logic [KEY_WIDTH-1:0] i_wr_key;
  logic [VAL_WIDTH-1:0] i_wr_val;

  modport master (
    output i_wr_valid,
    output i_wr_key,
    output i_wr_val,
    input  o_wr_ready
  );

  modport slave (
    input  i_wr_valid,
    input  i_wr_key,
    input  i_wr_val,
    output o_wr_ready
  );
endinterface

// File: rtl/mux_lut_loader.sv
// Run-time builder of the packed key/value table feeding the mux stage: appends new
// keys, overwrites values of known keys, and runs a KEY_NUM-cycle clear sequence.
module mux_lut_loader #(
  parameter  int KEY_NUM   = 2,
  parameter  int KEY_WIDTH = 1,
  parameter  int VAL_WIDTH = 1,
  localparam int PAIR      = KEY_WIDTH + VAL_WIDTH,
  localparam int CNT_W     = $clog2(KEY_NUM + 1),
  localparam int IDX_W     = $clog2(KEY_NUM)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  mux_lut_loader_if.slave         wr,
  output logic [KEY_NUM*PAIR-1:0] o_lut,
  output logic [CNT_W-1:0]        o_cnt,
  output logic                    o_full,
  output logic                    o_busy,
  output logic                    o_err
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  // Key in the upper bits of each entry; entry 0 sits at the LSB end of the table.
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } entry_t;

  state_t                   state_q;
  logic   [IDX_W-1:0]       clr_idx_q;
  entry_t [KEY_NUM-1:0]     table_q;
  logic   [CNT_W-1:0]       cnt_q;
  logic                     full_q;
  logic                     busy_q;
  logic                     err_q;

  logic                     hit;
  logic   [IDX_W-1:0]       hit_idx;

  assign wr.o_wr_ready = (state_q == IDLE) && !i_clr;

  assign o_lut  = table_q;
  assign o_cnt  = cnt_q;
  assign o_full = full_q;
  assign o_busy = busy_q;
  assign o_err  = err_q;

  // Scan downwards so the lowest matching valid index is the one left standing.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < cnt_q) && (table_q[i].key == wr.i_wr_key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      // NOTE: the table is reset because unused entries must read as zero on the mux input.
      table_q   <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_clr) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
          end else if (wr.i_wr_valid) begin
            if (hit) begin
              table_q[hit_idx].val <= wr.i_wr_val;
            end else if (!full_q) begin
              table_q[IDX_W'(cnt_q)] <= '{key: wr.i_wr_key, val: wr.i_wr_val};
              cnt_q                  <= cnt_q + 1'b1;
              full_q                 <= (cnt_q == CNT_W'(KEY_NUM - 1));
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        CLEAR: begin
          // i_clr is deliberately ignored here; the sequence always runs to completion.
          table_q[clr_idx_q] <= '0;
          if (clr_idx_q == IDX_W'(KEY_NUM - 1)) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_lut_loader.sv
// Directed bench for mux_lut_loader: a 4x(2+4) table for the main scenarios and a
// 4x(3+4) table where a full-table miss can actually be produced.
module tb_mux_lut_loader;

  logic clk;
  logic rst_n;
  logic clr;
  logic clr3;

  int n_cmp = 0;
  int n_bad = 0;

  mux_lut_loader_if #(.KEY_WIDTH(2), .VAL_WIDTH(4)) wr_if ();
  mux_lut_loader_if #(.KEY_WIDTH(3), .VAL_WIDTH(4)) wr3_if ();

  logic [23:0] lut;
  logic [2:0]  cnt;
  logic        full, busy, err;

  logic [27:0] lut3;
  logic [2:0]  cnt3;
  logic        full3, busy3, err3;

  mux_lut_loader #(.KEY_NUM(4), .KEY_WIDTH(2), .VAL_WIDTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (clr),
    .wr      (wr_if),
    .o_lut   (lut),
    .o_cnt   (cnt),
    .o_full  (full),
    .o_busy  (busy),
    .o_err   (err)
  );

  mux_lut_loader #(.KEY_NUM(4), .KEY_WIDTH(3), .VAL_WIDTH(4)) dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (clr3),
    .wr      (wr3_if),
    .o_lut   (lut3),
    .o_cnt   (cnt3),
    .o_full  (full3),
    .o_busy  (busy3),
    .o_err   (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; outputs are sampled on the falling edge too.
  task automatic wr_dut(input logic [1:0] key, input logic [3:0] val);
    @(negedge clk);
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_key   = key;
    wr_if.i_wr_val   = val;
    @(negedge clk);
    wr_if.i_wr_valid = 1'b0;
  endtask

  task automatic wr_dut3(input logic [2:0] key, input logic [3:0] val);
    @(negedge clk);
    wr3_if.i_wr_valid = 1'b1;
    wr3_if.i_wr_key   = key;
    wr3_if.i_wr_val   = val;
    @(negedge clk);
    wr3_if.i_wr_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_dut(2'd0, 4'h1);
    n_cmp++; if (lut !== 24'h000001) begin n_bad++; $display("FAIL pre_reset_lut: got %h want %h", lut, 24'h000001); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (lut !== 24'h0) begin n_bad++; $display("FAIL reset_lut: got %h want 0", lut); end
    n_cmp++; if (cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_cmp++; if ({full, busy, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {full, busy, err}); end
    n_cmp++; if (wr_if.o_wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", wr_if.o_wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_append();
    wr_dut(2'd1, 4'hA);
    n_cmp++; if (lut !== 24'h00001A) begin n_bad++; $display("FAIL append1_lut: got %h want %h", lut, 24'h00001A); end
    n_cmp++; if (cnt !== 3'd1) begin n_bad++; $display("FAIL append1_cnt: got %0d want 1", cnt); end
    // Second write driven by hand to observe the one-cycle latency.
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_key   = 2'd2;
    wr_if.i_wr_val   = 4'hB;
    #1;
    n_cmp++; if (cnt !== 3'd1) begin n_bad++; $display("FAIL append2_latency: got %0d want 1", cnt); end
    @(negedge clk);
    wr_if.i_wr_valid = 1'b0;
    n_cmp++; if (lut !== 24'h000ADA) begin n_bad++; $display("FAIL append2_lut: got %h want %h", lut, 24'h000ADA); end
    n_cmp++; if (cnt !== 3'd2) begin n_bad++; $display("FAIL append2_cnt: got %0d want 2", cnt); end
  endtask

  task automatic test_overwrite();
    wr_dut(2'd1, 4'h3);
    n_cmp++; if (lut !== 24'h000AD3) begin n_bad++; $display("FAIL overwrite_lut: got %h want %h", lut, 24'h000AD3); end
    n_cmp++; if (cnt !== 3'd2) begin n_bad++; $display("FAIL overwrite_cnt: got %0d want 2", cnt); end
  endtask

  task automatic test_idle_valid();
    @(negedge clk);
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_wr_key   = 2'd3;
    wr_if.i_wr_val   = 4'h9;
    repeat (2) @(negedge clk);
    n_cmp++; if (lut !== 24'h000AD3) begin n_bad++; $display("FAIL novalid_lut: got %h want %h", lut, 24'h000AD3); end
    n_cmp++; if (cnt !== 3'd2) begin n_bad++; $display("FAIL novalid_cnt: got %0d want 2", cnt); end
  endtask

  task automatic test_full();
    pulse_reset();
    wr_dut(2'd0, 4'h1);
    wr_dut(2'd1, 4'h2);
    wr_dut(2'd2, 4'h3);
    n_cmp++; if ({cnt, full} !== {3'd3, 1'b0}) begin n_bad++; $display("FAIL almost_full: got cnt %0d full %b want 3/0", cnt, full); end
    wr_dut(2'd3, 4'h4);
    n_cmp++; if (lut !== 24'hD23481) begin n_bad++; $display("FAIL full_lut: got %h want %h", lut, 24'hD23481); end
    n_cmp++; if ({cnt, full} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL full_cnt: got cnt %0d full %b want 4/1", cnt, full); end
    wr_dut(2'd2, 4'hF);
    n_cmp++; if (lut !== 24'hD2F481) begin n_bad++; $display("FAIL full_hit1_lut: got %h want %h", lut, 24'hD2F481); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_hit1_err: got %b want 0", err); end
    wr_dut(2'd2, 4'h5);
    n_cmp++; if (lut !== 24'hD25481) begin n_bad++; $display("FAIL full_hit2_lut: got %h want %h", lut, 24'hD25481); end
    n_cmp++; if ({cnt, err} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL full_hit2_state: got cnt %0d err %b want 4/0", cnt, err); end
  endtask

  task automatic test_full_miss();
    wr_dut3(3'd0, 4'h1);
    wr_dut3(3'd1, 4'h2);
    wr_dut3(3'd2, 4'h3);
    wr_dut3(3'd3, 4'h4);
    n_cmp++; if (lut3 !== 28'h688C901) begin n_bad++; $display("FAIL k3_fill_lut: got %h want %h", lut3, 28'h688C901); end
    n_cmp++; if ({cnt3, full3, err3} !== {3'd4, 1'b1, 1'b0}) begin n_bad++; $display("FAIL k3_fill_flags: got %b want %b", {cnt3, full3, err3}, {3'd4, 1'b1, 1'b0}); end
    wr_dut3(3'd5, 4'h9);
    n_cmp++; if (lut3 !== 28'h688C901) begin n_bad++; $display("FAIL k3_miss_lut: got %h want %h", lut3, 28'h688C901); end
    n_cmp++; if ({cnt3, err3} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL k3_miss_err: got cnt %0d err %b want 4/1", cnt3, err3); end
    wr_dut3(3'd0, 4'hE);
    n_cmp++; if (lut3 !== 28'h688C90E) begin n_bad++; $display("FAIL k3_hit_lut: got %h want %h", lut3, 28'h688C90E); end
    n_cmp++; if (err3 !== 1'b1) begin n_bad++; $display("FAIL k3_err_sticky: got %b want 1", err3); end
  endtask

  task automatic test_clear();
    @(negedge clk);
    clr              = 1'b1;
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_key   = 2'd3;
    wr_if.i_wr_val   = 4'h0;
    #1;
    n_cmp++; if (wr_if.o_wr_ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready_start: got %b want 0", wr_if.o_wr_ready); end
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({busy, wr_if.o_wr_ready} !== 2'b10) begin n_bad++; $display("FAIL clr_busy_%0d: got busy/ready %b want 10", k, {busy, wr_if.o_wr_ready}); end
      if (k == 1) begin
        n_cmp++; if (lut !== 24'hD25480) begin n_bad++; $display("FAIL clr_partial_lut: got %h want %h", lut, 24'hD25480); end
      end
      // A second clear request mid-sequence must not restart it.
      clr = (k == 2);
      @(negedge clk);
      clr = 1'b0;
    end
    n_cmp++; if (lut !== 24'h0) begin n_bad++; $display("FAIL clr_done_lut: got %h want 0", lut); end
    n_cmp++; if ({cnt, full, busy, err} !== 6'b0) begin n_bad++; $display("FAIL clr_done_state: got %b want 0", {cnt, full, busy, err}); end
    n_cmp++; if (wr_if.o_wr_ready !== 1'b1) begin n_bad++; $display("FAIL clr_done_ready: got %b want 1", wr_if.o_wr_ready); end
    wr_if.i_wr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    wr_dut(2'd1, 4'hA);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midclr_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({lut, cnt, full, busy, err} !== 30'b0) begin n_bad++; $display("FAIL midclr_reset: got lut %h cnt %0d flags %b", lut, cnt, {full, busy, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, wr_if.o_wr_ready} !== 2'b01) begin n_bad++; $display("FAIL midclr_idle: got busy/ready %b want 01", {busy, wr_if.o_wr_ready}); end
    wr_dut(2'd3, 4'h7);
    n_cmp++; if (lut !== 24'h000037) begin n_bad++; $display("FAIL midclr_write_lut: got %h want %h", lut, 24'h000037); end
    n_cmp++; if (cnt !== 3'd1) begin n_bad++; $display("FAIL midclr_write_cnt: got %0d want 1", cnt); end
  endtask

  initial begin
    rst_n             = 1'b0;
    clr               = 1'b0;
    clr3              = 1'b0;
    wr_if.i_wr_valid  = 1'b0;
    wr_if.i_wr_key    = '0;
    wr_if.i_wr_val    = '0;
    wr3_if.i_wr_valid = 1'b0;
    wr3_if.i_wr_key   = '0;
    wr3_if.i_wr_val   = '0;

    test_reset();
    test_append();
    test_overwrite();
    test_idle_valid();
    test_full();
    test_full_miss();
    test_clear();
    test_reset_mid_clear();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_lut_loader.md
Name: mux_lut_loader

Overview:
- Run-time loader that builds the packed key/value lookup table consumed by the mux_key / mux stages.
- Accepts entries one at a time over a valid/ready write port. A new key is appended; an existing key has its value overwritten in place.
- Presents the flattened table as o_lut, wired directly to the mux i_lut input.
- Supports a multi-cycle clear sequence and flags writes that are dropped because the table is full.

Parameters:
- KEY_NUM, 2, number of table entries (>=2)
- KEY_WIDTH, 1, key width in bits
- VAL_WIDTH, 1, value width in bits

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_clr  input  1  start clear sequence (level sampled per cycle)
- i_wr_valid  input  1  write request
- o_wr_ready  output  1  write port can accept
- i_wr_key  input  KEY_WIDTH  key to write
- i_wr_val  input  VAL_WIDTH  value to write
- o_lut  output  KEY_NUM*(KEY_WIDTH+VAL_WIDTH)  packed table for the mux
- o_cnt  output  $clog2(KEY_NUM+1)  number of valid entries
- o_full  output  1  o_cnt == KEY_NUM
- o_busy  output  1  clear sequence in progress
- o_err  output  1  sticky: a write was dropped because the table was full

Behaviour:
- One clock domain (i_clk). Reset is asynchronous, active-low (i_rst_n). All state is registered.
- Reset values:
  - o_lut = 0, o_cnt = 0, o_full = 0, o_busy = 0, o_err = 0
  - FSM = IDLE, clear index = 0
- Packing: PAIR = KEY_WIDTH+VAL_WIDTH. Entry i occupies o_lut[(i+1)*PAIR-1 : i*PAIR].
  - Key is in the upper KEY_WIDTH bits of the entry, value in the lower VAL_WIDTH bits.
  - Unused entries are all-zero.
- o_wr_ready = (state == IDLE) && !i_clr. This is combinational and does not depend on i_wr_valid or i_wr_key.
- A write is accepted on a rising edge with i_wr_valid && o_wr_ready. Effect is visible on o_lut/o_cnt the next cycle (1-cycle latency).
- Hit detection: compare i_wr_key only against entries with index < o_cnt. If several match, the lowest index is the hit.
- Accepted write, hit: overwrite that entry's value field. Key field and o_cnt are unchanged. Allowed even when full.
- Accepted write, miss, not full: write {key,val} to entry o_cnt and increment o_cnt.
- Accepted write, miss, full: table is unchanged and o_err is set to 1. o_err stays 1 until reset or the end of a clear.
- FSM states:
  - IDLE: i_clr=1 goes to CLEAR, sets clear index = 0 and o_busy = 1; any write that cycle is not accepted.
  - CLEAR: each cycle zeroes entry[clear index] and increments the index.
  - CLEAR completion: on the cycle the index reaches KEY_NUM-1, set o_cnt = 0, o_err = 0, o_busy = 0 and return to IDLE.
  - Clear lasts exactly KEY_NUM cycles; o_wr_ready is low throughout.
  - i_clr asserted during CLEAR is ignored and does not restart the sequence.
- Derived outputs: o_full is registered and consistent with o_cnt in the same cycle. o_busy = (state == CLEAR).
- Reset mid-CLEAR or mid-write: immediate return to reset values; no partial entry survives.
- Writes while i_wr_valid=0 are ignored, whatever the key/value inputs.
- Stalled requester: o_wr_ready low does not consume the request; the requester holds i_wr_* until accepted.

Test Plan (KEY_NUM=4, KEY_WIDTH=2, VAL_WIDTH=4, PAIR=6):
- Reset: assert i_rst_n=0 asynchronously mid-cycle -> o_lut=24'h0, o_cnt=0, o_full=0, o_err=0, o_wr_ready=1 immediately.
- Append: write (key 1,val 4'hA), then (key 2,val 4'hB) -> o_lut=24'h000ADA, o_cnt=2, each change visible the cycle after acceptance.
- Overwrite: from previous state, write (key 1,val 4'h3) -> o_lut=24'h000AD3, o_cnt stays 2.
- Full: fill with keys 0..3, vals 1..4 -> o_full=1, o_cnt=4.
  - Then write (key 2,val 4'hF) -> entry2 value = F, o_err=0.
  - Then, with the table still full, write (key 2,val 4'h5) -> entry2 value = 5, o_err stays 0 (hit is always accepted).
  - With all keys 0..3 present a full-table miss cannot be produced. Separately, fill with keys {0,1,2,3} using KEY_WIDTH=3 and write key 5 -> table unchanged, o_err=1 (sticky).
- Clear: from the full state, pulse i_clr one cycle while i_wr_valid=1 -> write not accepted.
  - o_busy=1 and o_wr_ready=0 for 4 cycles.
  - Then o_lut=0, o_cnt=0, o_err=0, o_wr_ready=1.
- Reset mid-clear: assert i_rst_n=0 on the 2nd CLEAR cycle -> all outputs at reset values, state IDLE after release.
  - A following write of (key 3,val 4'h7) -> o_lut=24'h000037.
